// File: rtl/chia_xung_div_pkg.sv
// Shared helpers for the chia_xung_div clock divider.
// Provides the counter-width calculation used by the top level and
// by any other divider that reuses mod_counter.
package chia_xung_div_pkg;

  // Counter width for a modulus n: at least one bit, even when n <= 2.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/chia_xung_div_mod_counter.sv
// mod_counter: free-running modulo-MODULUS up-counter.
// Ports:
//   clk   - clock, rising edge active
//   reset - synchronous active-high clear
//   cnt   - current count, 0..MODULUS-1
//   wrap  - high while cnt == MODULUS-1 (next edge returns to 0)
module mod_counter #(
  parameter int MODULUS = 4,
  parameter int W       = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/chia_xung_div.sv
// chia_xung_div: synchronous clock divider producing a registered,
// glitch-free waveform q with period DIV_RATIO and HIGH_CYCLES high
// cycles per period; the low phase comes first after reset.
// Ports:
//   clk   - system clock, rising edge active
//   reset - synchronous active-high; clears counter and q
//   q     - divided output, straight from a flip-flop
module chia_xung_div
  import chia_xung_div_pkg::*;
#(
  parameter int DIV_RATIO   = 4,
  parameter int HIGH_CYCLES = DIV_RATIO / 2
) (
  input  logic clk,
  input  logic reset,
  output logic q
);

  localparam int CNT_W      = cnt_width(DIV_RATIO);
  localparam int LOW_CYCLES = DIV_RATIO - HIGH_CYCLES;
  localparam logic [CNT_W-1:0] LOW_C = CNT_W'(LOW_CYCLES);

  if (DIV_RATIO < 2 || HIGH_CYCLES < 1 || HIGH_CYCLES > DIV_RATIO - 1) begin : g_param_err
    $fatal(1, "chia_xung_div: illegal parameters DIV_RATIO=%0d HIGH_CYCLES=%0d",
           DIV_RATIO, HIGH_CYCLES);
  end

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_q;
  logic             q_d;

  mod_counter #(
    .MODULUS (DIV_RATIO),
    .W       (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // q is decoded from the counter's next value so it changes on the
  // same edge as cnt, keeping q == (cnt >= LOW_CYCLES) after every edge.
  always_comb begin
    cnt_nxt = wrap ? '0 : cnt + 1'b1;
    q_d     = (cnt_nxt >= LOW_C);
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_chia_xung_div.sv
module tb_chia_xung_div;

  logic clk;
  logic reset;
  logic q4, q10, q5, q2, q7;

  int checks = 0;
  int errors = 0;

  chia_xung_div d4 (.clk(clk), .reset(reset), .q(q4));
  chia_xung_div #(.DIV_RATIO(10)) d10 (.clk(clk), .reset(reset), .q(q10));
  chia_xung_div #(.DIV_RATIO(5), .HIGH_CYCLES(1)) d5 (.clk(clk), .reset(reset), .q(q5));
  chia_xung_div #(.DIV_RATIO(2)) d2 (.clk(clk), .reset(reset), .q(q2));
  chia_xung_div #(.DIV_RATIO(7), .HIGH_CYCLES(5)) d7 (.clk(clk), .reset(reset), .q(q7));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive reset away from the active edge, then sample 1 ns after it.
  task automatic step(input logic rst);
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] exp;   // {d4, d10, d5h1, d2}
  } vec_t;

  vec_t tbl[17];

  // Reference model: phase within the period is edges-since-reset mod N;
  // the output is high in the last H positions of the period.
  int ratio[5] = '{4, 10, 5, 2, 7};
  int highc[5] = '{2, 5, 1, 1, 5};
  int k;

  function automatic bit ref_q(input int kk, input int n, input int h);
    return (kk % n) >= (n - h);
  endfunction

  initial begin
    logic [4:0] qv;
    int highs;
    int rises;
    logic prev;

    reset = 1'b1;

    tbl[0]  = '{1'b1, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0001};
    tbl[2]  = '{1'b0, 4'b1000};
    tbl[3]  = '{1'b0, 4'b1001};
    tbl[4]  = '{1'b0, 4'b0010};
    tbl[5]  = '{1'b0, 4'b0101};
    tbl[6]  = '{1'b0, 4'b1100};
    tbl[7]  = '{1'b0, 4'b1101};
    tbl[8]  = '{1'b0, 4'b0100};
    tbl[9]  = '{1'b0, 4'b0111};
    tbl[10] = '{1'b0, 4'b1000};
    tbl[11] = '{1'b0, 4'b1001};
    tbl[12] = '{1'b1, 4'b0000};   // reset while d4 is high
    tbl[13] = '{1'b0, 4'b0001};
    tbl[14] = '{1'b0, 4'b1000};
    tbl[15] = '{1'b0, 4'b1001};
    tbl[16] = '{1'b0, 4'b0010};

    // First edge at 10 ns with reset high.
    @(posedge clk);
    #1;
    chk("reset_q4", q4, 0);
    chk("reset_cnt4", int'(d4.u_cnt.cnt), 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst);
      chk($sformatf("tbl%0d_d4", i),  q4,  tbl[i].exp[3]);
      chk($sformatf("tbl%0d_d10", i), q10, tbl[i].exp[2]);
      chk($sformatf("tbl%0d_d5", i),  q5,  tbl[i].exp[1]);
      chk($sformatf("tbl%0d_d2", i),  q2,  tbl[i].exp[0]);
      if (tbl[i].rst) chk($sformatf("tbl%0d_cnt4", i), int'(d4.u_cnt.cnt), 0);
    end

    // DIV_RATIO=10: three full periods, 15 high cycles and 3 rising edges.
    step(1'b1);
    highs = 0;
    rises = 0;
    prev  = q10;
    for (int i = 0; i < 30; i++) begin
      step(1'b0);
      if (q10) highs++;
      if (q10 && !prev) rises++;
      prev = q10;
    end
    chk("d10_high_cycles", highs, 15);
    chk("d10_rises", rises, 3);
    chk("d10_end_low", q10, 0);

    // DIV_RATIO=5, HIGH=1: pulses exactly after edges 4, 9, 14.
    step(1'b1);
    for (int e = 1; e <= 15; e++) begin
      step(1'b0);
      chk($sformatf("d5_pulse_e%0d", e), q5, (e == 4 || e == 9 || e == 14) ? 1 : 0);
    end

    // Randomized resets against the arithmetic model.
    step(1'b1);
    k = 0;
    for (int c = 0; c < 400; c++) begin
      logic r;
      r = ($urandom_range(0, 19) == 0);
      step(r);
      k = r ? 0 : k + 1;
      qv = {q7, q2, q5, q10, q4};
      for (int j = 0; j < 5; j++)
        chk($sformatf("rnd%0d_n%0d", c, ratio[j]), qv[j], ref_q(k, ratio[j], highc[j]));
      chk($sformatf("rnd%0d_cnt4", c), int'(d4.u_cnt.cnt), k % 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
